// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook-timer controller.
// Holds the controller state encoding, the BCD digit width, the default
// timing parameters and a helper that sizes counters.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_COOK,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam int BCD_W                = 4;
    localparam int TICK_DIV_DEFAULT     = 100;
    localparam int ALARM_CYCLES_DEFAULT = 300;

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one tick per TICK_DIV cycles for the cook timer.
// Ports:
//   clk     - system clock, rising edge
//   clear   - asynchronous active-high reset
//   restart - synchronous return of the count to 0 (fresh cook)
//   run     - count advances only while high; held otherwise (pause)
//   tick    - high for the cycle in which the count sits at TICK_DIV-1
module tick_prescaler
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    input  logic run,
    output logic tick
);

    localparam int            CW   = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && !restart && (cnt_q == LAST);

endmodule

// File: rtl/microwave_controller.sv
// Sequencing controller for the microwave's 3-digit BCD min:sec timer.
// Shifts keypad digits into the timer, gates its count enable through the
// tick prescaler while cooking, drives the magnetron and handles door-open,
// pause, stop/cancel and the end-of-cook alarm. All outputs are registered.
//
// state | meaning
// IDLE  | nothing entered; stop clears the timer
// SET   | digits being entered; start begins cooking
// COOK  | magnetron on, timer counting down
// PAUSE | door opened or stop pressed mid-cook; prescaler count held
// DONE  | timer reached 0:00, alarm sounding
//
// Ports:
//   clk, clear            - clock and asynchronous active-high reset
//   key_valid, key_digit  - keypad strobe and digit (values > 9 ignored)
//   start, stop           - front-panel buttons, level sampled
//   door_closed           - 1 when the door is latched
//   timer_zero            - timer reads 0:00
//   timer_bcd, timer_load - digit and shift-in pulse to the timer
//   timer_clear           - clear pulse to the timer
//   timer_en              - one-decrement pulse to the timer
//   magnetron_on, alarm, cooking - heater, buzzer and status
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int ALARM_CYCLES = ALARM_CYCLES_DEFAULT,
    parameter int MAX_DIGITS   = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_digit,
    input  logic             start,
    input  logic             stop,
    input  logic             door_closed,
    input  logic             timer_zero,
    output logic [BCD_W-1:0] timer_bcd,
    output logic             timer_load,
    output logic             timer_clear,
    output logic             timer_en,
    output logic             magnetron_on,
    output logic             alarm,
    output logic             cooking
);

    localparam int            AW         = cnt_width(ALARM_CYCLES);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);
    localparam logic [1:0]    DIGITS_MAX = 2'(MAX_DIGITS);

    state_t           state_q, state_d;
    logic [1:0]       digit_cnt_q, digit_cnt_d;
    logic [AW-1:0]    alarm_cnt_q, alarm_cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             load_q, load_d;
    logic             clr_q, clr_d;
    logic             en_q, en_d;
    logic             mag_q, mag_d;
    logic             alarm_q, alarm_d;
    logic             cooking_q, cooking_d;

    logic             key_ok;
    logic             load_take;
    logic             clear_take;
    logic             presc_restart;
    logic             tick;

    assign key_ok = key_valid && (key_digit <= 4'd9);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .clear  (clear),
        .restart(presc_restart),
        .run    (state_q == ST_COOK),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            digit_cnt_q <= '0;
            alarm_cnt_q <= '0;
            bcd_q       <= '0;
            load_q      <= 1'b0;
            clr_q       <= 1'b0;
            en_q        <= 1'b0;
            mag_q       <= 1'b0;
            alarm_q     <= 1'b0;
            cooking_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            alarm_cnt_q <= alarm_cnt_d;
            bcd_q       <= bcd_d;
            load_q      <= load_d;
            clr_q       <= clr_d;
            en_q        <= en_d;
            mag_q       <= mag_d;
            alarm_q     <= alarm_d;
            cooking_q   <= cooking_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        digit_cnt_d   = digit_cnt_q;
        alarm_cnt_d   = alarm_cnt_q;
        load_take     = 1'b0;
        clear_take    = 1'b0;
        presc_restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    clear_take = 1'b1;
                end else if (key_ok) begin
                    load_take   = 1'b1;
                    digit_cnt_d = 2'd1;
                    state_d     = ST_SET;
                end
            end
            ST_SET: begin
                if (stop) begin
                    clear_take = 1'b1;
                    state_d    = ST_IDLE;
                end else if (start && door_closed && !timer_zero) begin
                    presc_restart = 1'b1;
                    state_d       = ST_COOK;
                end else if (key_ok && (digit_cnt_q < DIGITS_MAX)) begin
                    load_take   = 1'b1;
                    digit_cnt_d = digit_cnt_q + 2'd1;
                end
            end
            ST_COOK: begin
                // Reaching 0:00 outranks door/stop so the cook still ends cleanly.
                if (timer_zero) begin
                    alarm_cnt_d = '0;
                    state_d     = ST_DONE;
                end else if (!door_closed || stop) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    clear_take = 1'b1;
                    state_d    = ST_IDLE;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop || (alarm_cnt_q == ALARM_LAST)) begin
                    clear_take = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_IDLE) begin
            digit_cnt_d = '0;
        end
    end

    always_comb begin
        load_d    = load_take;
        bcd_d     = load_take ? key_digit : bcd_q;
        clr_d     = clear_take;
        // A decrement only goes out if cooking continues past this edge, so a
        // tick landing on door-open, stop or 0:00 is dropped.
        en_d      = (state_q == ST_COOK) && (state_d == ST_COOK) && tick;
        mag_d     = (state_d == ST_COOK);
        cooking_d = (state_d == ST_COOK);
        alarm_d   = (state_d == ST_DONE);
    end

    assign timer_bcd    = bcd_q;
    assign timer_load   = load_q;
    assign timer_clear  = clr_q;
    assign timer_en     = en_q;
    assign magnetron_on = mag_q;
    assign alarm        = alarm_q;
    assign cooking      = cooking_q;

endmodule

// File: tb/tb_microwave_controller.sv
`timescale 1ns/1ps
module tb_microwave_controller;

    localparam int TDIV = 10;
    localparam int ACYC = 20;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic       timer_zero;
    logic [3:0] timer_bcd;
    logic       timer_load, timer_clear, timer_en;
    logic       magnetron_on, alarm, cooking;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    int n;
    int en_seen;

    always #5 clk = ~clk;

    microwave_controller #(
        .TICK_DIV    (TDIV),
        .ALARM_CYCLES(ACYC),
        .MAX_DIGITS  (3)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .timer_bcd   (timer_bcd),
        .timer_load  (timer_load),
        .timer_clear (timer_clear),
        .timer_en    (timer_en),
        .magnetron_on(magnetron_on),
        .alarm       (alarm),
        .cooking     (cooking)
    );

    // Behavioural min:sec BCD timer driven by the controller.
    logic [3:0] t_min, t_ten, t_one;
    always @(posedge clk or posedge clear) begin
        if (clear) begin
            t_min <= 4'd0; t_ten <= 4'd0; t_one <= 4'd0;
        end else if (timer_clear) begin
            t_min <= 4'd0; t_ten <= 4'd0; t_one <= 4'd0;
        end else if (timer_load) begin
            t_min <= t_ten; t_ten <= t_one; t_one <= timer_bcd;
        end else if (timer_en) begin
            if (t_one != 4'd0) begin
                t_one <= t_one - 4'd1;
            end else if (t_ten != 4'd0) begin
                t_ten <= t_ten - 4'd1; t_one <= 4'd9;
            end else if (t_min != 4'd0) begin
                t_min <= t_min - 4'd1; t_ten <= 4'd5; t_one <= 4'd9;
            end
        end
    end
    assign timer_zero = (t_min == 4'd0) && (t_ten == 4'd0) && (t_one == 4'd0);

    // timer_en must never appear outside COOK or while the timer reads 0:00.
    always @(posedge clk) begin
        if (!clear && timer_en && (!cooking || timer_zero)) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({timer_bcd, timer_load, timer_clear, timer_en, magnetron_on, alarm, cooking});
    endfunction

    function automatic logic [31:0] tval();
        return 32'({t_min, t_ten, t_one});
    endfunction

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_en(output int cnt);
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (timer_en) break;
        end
    endtask

    initial begin
        cyc(2);
        chk("reset_outputs", outs(), 32'h0);
        clear = 1'b0;
        cyc(1);
        chk("idle_outputs", outs(), 32'h0);

        // Digit entry
        press_key(4'd12); chk("key12_noload", 32'(timer_load), 32'h0);
        press_key(4'd1);  chk("load1", 32'(timer_load), 32'h1); chk("bcd1", 32'(timer_bcd), 32'h1);
        cyc(1);           chk("load1_one_cycle", 32'(timer_load), 32'h0);
        press_key(4'd3);  chk("load3", 32'(timer_load), 32'h1); chk("bcd3", 32'(timer_bcd), 32'h3);
        press_key(4'd0);  chk("load0", 32'(timer_load), 32'h1); chk("bcd0", 32'(timer_bcd), 32'h0);
        press_key(4'd5);  chk("key4_ignored", 32'(timer_load), 32'h0); chk("bcd_held", 32'(timer_bcd), 32'h0);
        cyc(1);           chk("timer_130", tval(), 32'h130);

        // Start with the door open is ignored
        door_closed = 1'b0;
        pulse_start();    chk("start_door_open", 32'(cooking), 32'h0);
        door_closed = 1'b1;
        cyc(1);           chk("still_not_cooking", 32'(magnetron_on), 32'h0);

        // Cook
        pulse_start();
        chk("cook_entry_mag", 32'(magnetron_on), 32'h1);
        chk("cook_entry_cooking", 32'(cooking), 32'h1);
        wait_en(n); chk("first_en_latency", 32'(n), 32'(TDIV));
        wait_en(n); chk("en_period", 32'(n), 32'(TDIV));

        // Door opens 2.5 ticks into the cook
        cyc(4);
        door_closed = 1'b0;
        cyc(1);
        chk("door_open_mag", 32'(magnetron_on), 32'h0);
        chk("door_open_cooking", 32'(cooking), 32'h0);
        en_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (timer_en) en_seen++;
        end
        chk("pause_no_en", 32'(en_seen), 32'h0);
        chk("pause_timer_held", tval(), 32'h128);
        door_closed = 1'b1;
        pulse_start();    chk("resume_cooking", 32'(cooking), 32'h1);
        wait_en(n); chk("resume_en_latency", 32'(n), 32'(TDIV / 2));

        // Run to 0:00
        en_seen = 3;
        n = 0;
        while (!alarm && n < 2000) begin
            @(negedge clk);
            n++;
            if (timer_en) en_seen++;
        end
        chk("en_count_total", 32'(en_seen), 32'd90);
        chk("done_alarm", 32'(alarm), 32'h1);
        chk("done_mag_off", 32'(magnetron_on), 32'h0);
        chk("done_timer_zero", 32'(timer_zero), 32'h1);
        n = 1;
        while (alarm && n < 1000) begin
            @(negedge clk);
            if (alarm) n++;
        end
        chk("alarm_len", 32'(n), 32'(ACYC));
        chk("done_timer_clear", 32'(timer_clear), 32'h1);

        // Start with the timer at 0:00 is ignored; stop in SET clears
        cyc(1);
        press_key(4'd0);  chk("load_zero", 32'(timer_load), 32'h1);
        cyc(1);
        pulse_start();    chk("start_timer_zero", 32'(cooking), 32'h0);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("set_stop_clear", 32'(timer_clear), 32'h1);

        // timer_zero and door open sampled together -> DONE
        cyc(1);
        press_key(4'd1);
        cyc(1);
        pulse_start();    chk("short_cooking", 32'(cooking), 32'h1);
        wait_en(n);       chk("short_en", 32'(n), 32'(TDIV));
        cyc(1);
        door_closed = 1'b0;
        cyc(1);
        chk("zero_beats_door", 32'(alarm), 32'h1);
        chk("zero_beats_door_mag", 32'(magnetron_on), 32'h0);
        door_closed = 1'b1;
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("done_stop_clear", 32'(timer_clear), 32'h1);
        chk("done_stop_alarm_off", 32'(alarm), 32'h0);

        // Stop pauses; start+stop in PAUSE cancels
        cyc(1);
        press_key(4'd2);
        cyc(1);
        pulse_start();    chk("pause_test_cooking", 32'(cooking), 32'h1);
        cyc(3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("stop_pauses", 32'(cooking), 32'h0);
        chk("stop_pause_no_clear", 32'(timer_clear), 32'h0);
        press_key(4'd7);  chk("pause_key_ignored", 32'(timer_load), 32'h0);
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        chk("pause_start_stop_clear", 32'(timer_clear), 32'h1);
        chk("pause_start_stop_idle", 32'(cooking), 32'h0);
        cyc(1);
        chk("pause_stop_timer_cleared", tval(), 32'h0);

        // Reset mid-cook
        press_key(4'd5);
        cyc(1);
        pulse_start();
        cyc(3);
        chk("pre_reset_mag", 32'(magnetron_on), 32'h1);
        #2 clear = 1'b1;
        #1 chk("async_clear_mag", 32'(magnetron_on), 32'h0);
        @(negedge clk);
        clear = 1'b0;
        cyc(1);
        chk("post_reset_outputs", outs(), 32'h0);
        cyc(2);
        chk("en_invariant", 32'(viol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
